// File: rtl/planificador_ascensor.sv
// Four-floor elevator scheduler: latches hall/cabin requests, picks travel direction,
// drives the motor and sequences each stop around the door controller's busy signal.
module planificador_ascensor #(
  parameter int T_ESPERA = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] botones,
  input  logic       sensor_piso,
  input  logic       trabajando,
  output logic [9:0] pisos,
  output logic [3:0] estado,
  output logic [1:0] motor
);

  localparam int CW = (T_ESPERA > 1) ? $clog2(T_ESPERA + 1) : 1;

  typedef enum logic [1:0] {
    REPOSO   = 2'd0,
    MOVIENDO = 2'd1,
    DETENIDO = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      floor_q, floor_d;
  logic            dir_q, dir_d;
  logic [9:0]      pisos_q, pisos_d;
  logic [3:0]      estado_q, estado_d;
  logic [1:0]      motor_q, motor_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            seen_q, seen_d;
  logic [9:0]      clr_s;
  logic [1:0]      next_floor_s;

  function automatic logic hall_up(input logic [9:0] p, input logic [1:0] f);
    case (f)
      2'd0:    hall_up = p[0];
      2'd1:    hall_up = p[1];
      2'd2:    hall_up = p[3];
      default: hall_up = 1'b0;
    endcase
  endfunction

  function automatic logic hall_dn(input logic [9:0] p, input logic [1:0] f);
    case (f)
      2'd0:    hall_dn = 1'b0;
      2'd1:    hall_dn = p[2];
      2'd2:    hall_dn = p[4];
      default: hall_dn = p[5];
    endcase
  endfunction

  function automatic logic cabin(input logic [9:0] p, input logic [1:0] f);
    case (f)
      2'd0:    cabin = p[6];
      2'd1:    cabin = p[7];
      2'd2:    cabin = p[8];
      default: cabin = p[9];
    endcase
  endfunction

  function automatic logic any_at(input logic [9:0] p, input logic [1:0] f);
    any_at = cabin(p, f) | hall_up(p, f) | hall_dn(p, f);
  endfunction

  // Any request strictly beyond floor f when travelling in direction d (1 = down).
  function automatic logic ahead(input logic [9:0] p, input logic [1:0] f, input logic d);
    ahead = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (d ? (i < int'(f)) : (i > int'(f))) begin
        ahead = ahead | any_at(p, 2'(i));
      end
    end
  endfunction

  function automatic logic should_stop(input logic [9:0] p, input logic [1:0] f, input logic d);
    should_stop = cabin(p, f) | (d ? hall_dn(p, f) : hall_up(p, f))
                | (any_at(p, f) & ~ahead(p, f, d));
  endfunction

  function automatic logic must_flip(input logic [9:0] p, input logic [1:0] f, input logic d);
    must_flip = ~ahead(p, f, d) & ~cabin(p, f) & ~(d ? hall_dn(p, f) : hall_up(p, f))
              & (d ? hall_up(p, f) : hall_dn(p, f));
  endfunction

  // The end floors have a single hall button, so it is served regardless of direction.
  function automatic logic [9:0] serve_mask(input logic [1:0] f, input logic d);
    serve_mask = 10'd0;
    case (f)
      2'd0: begin
        serve_mask[6] = 1'b1;
        serve_mask[0] = 1'b1;
      end
      2'd1: begin
        serve_mask[7] = 1'b1;
        if (d) serve_mask[2] = 1'b1;
        else   serve_mask[1] = 1'b1;
      end
      2'd2: begin
        serve_mask[8] = 1'b1;
        if (d) serve_mask[4] = 1'b1;
        else   serve_mask[3] = 1'b1;
      end
      default: begin
        serve_mask[9] = 1'b1;
        serve_mask[5] = 1'b1;
      end
    endcase
  endfunction

  always_comb begin
    state_d      = state_q;
    floor_d      = floor_q;
    dir_d        = dir_q;
    cnt_d        = '0;
    seen_d       = 1'b0;
    clr_s        = 10'd0;
    next_floor_s = dir_q ? (floor_q - 2'd1) : (floor_q + 2'd1);

    case (state_q)
      REPOSO: begin
        // Only a call this stop would actually clear holds the cabin here; otherwise
        // an opposite-direction hall call could re-open the doors forever.
        if (should_stop(pisos_q, floor_q, dir_q)) begin
          state_d = DETENIDO;
          if (must_flip(pisos_q, floor_q, dir_q)) dir_d = ~dir_q;
        end else if (ahead(pisos_q, floor_q, dir_q)) begin
          state_d = MOVIENDO;
        end else if (ahead(pisos_q, floor_q, ~dir_q)) begin
          state_d = MOVIENDO;
          dir_d   = ~dir_q;
        end else begin
          state_d = REPOSO;
        end
      end

      MOVIENDO: begin
        if (!sensor_piso) begin
          state_d = MOVIENDO;
        end else if ((dir_q && floor_q == 2'd0) || (!dir_q && floor_q == 2'd3)) begin
          state_d = DETENIDO;
          if (must_flip(pisos_q, floor_q, dir_q)) dir_d = ~dir_q;
        end else begin
          floor_d = next_floor_s;
          if (should_stop(pisos_q, next_floor_s, dir_q)) begin
            state_d = DETENIDO;
            if (must_flip(pisos_q, next_floor_s, dir_q)) dir_d = ~dir_q;
          end else begin
            state_d = MOVIENDO;
          end
        end
      end

      DETENIDO: begin
        // seen_q marks that the doors have started working; their release ends the stop.
        if (seen_q) begin
          if (!trabajando) begin
            clr_s   = serve_mask(floor_q, dir_q);
            state_d = REPOSO;
          end else begin
            seen_d = 1'b1;
          end
        end else if (trabajando) begin
          seen_d = 1'b1;
        end else if (cnt_q == CW'(T_ESPERA - 1)) begin
          clr_s   = serve_mask(floor_q, dir_q);
          state_d = REPOSO;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = REPOSO;
      end
    endcase

    pisos_d  = (pisos_q & ~clr_s) | botones;
    motor_d  = (state_d == MOVIENDO) ? (dir_d ? 2'b10 : 2'b01) : 2'b00;
    estado_d = {(state_d == MOVIENDO), dir_d, floor_d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= REPOSO;
      floor_q  <= 2'd0;
      dir_q    <= 1'b0;
      pisos_q  <= 10'd0;
      estado_q <= 4'd0;
      motor_q  <= 2'b00;
      cnt_q    <= '0;
      seen_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      floor_q  <= floor_d;
      dir_q    <= dir_d;
      pisos_q  <= pisos_d;
      estado_q <= estado_d;
      motor_q  <= motor_d;
      cnt_q    <= cnt_d;
      seen_q   <= seen_d;
    end
  end

  assign pisos  = pisos_q;
  assign estado = estado_q;
  assign motor  = motor_q;

endmodule

// File: tb/tb_planificador_ascensor.sv
// Directed scoreboard bench for planificador_ascensor: each step queues the expected
// outputs, applies one clock, then pops and checks them.
module tb_planificador_ascensor;

  logic       clk;
  logic       rst;
  logic [9:0] botones;
  logic       sensor_piso;
  logic       trabajando;
  logic [9:0] pisos;
  logic [3:0] estado;
  logic [1:0] motor;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    string      tag;
    logic [9:0] p;
    logic [3:0] e;
    logic [1:0] m;
  } exp_t;

  exp_t sb[$];

  planificador_ascensor #(.T_ESPERA(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .botones     (botones),
    .sensor_piso (sensor_piso),
    .trabajando  (trabajando),
    .pisos       (pisos),
    .estado      (estado),
    .motor       (motor)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_out();
    exp_t x;
    tests_run++;
    assert (sb.size() > 0) else begin
      tests_failed++;
      $error("FAIL scoreboard: observed empty queue, expected an entry");
    end
    if (sb.size() > 0) begin
      x = sb.pop_front();
      tests_run++;
      assert (pisos === x.p) else begin
        tests_failed++;
        $error("FAIL %s pisos: observed %h expected %h", x.tag, pisos, x.p);
      end
      tests_run++;
      assert (estado === x.e) else begin
        tests_failed++;
        $error("FAIL %s estado: observed %b expected %b", x.tag, estado, x.e);
      end
      tests_run++;
      assert (motor === x.m) else begin
        tests_failed++;
        $error("FAIL %s motor: observed %b expected %b", x.tag, motor, x.m);
      end
    end
  endtask

  task automatic step(input logic [9:0] b, input logic s, input logic t, input string tag,
                      input logic [9:0] p, input logic [3:0] e, input logic [1:0] m);
    exp_t x;
    botones     = b;
    sensor_piso = s;
    trabajando  = t;
    x.tag = tag;
    x.p   = p;
    x.e   = e;
    x.m   = m;
    sb.push_back(x);
    @(posedge clk);
    #1;
    botones     = 10'd0;
    sensor_piso = 1'b0;
    check_out();
  endtask

  initial begin
    rst = 1'b1;
    botones = 10'd0;
    sensor_piso = 1'b0;
    trabajando = 1'b0;

    // Reset drops requests presented while it is asserted.
    step(10'h3FF, 1'b1, 1'b1, "rst0", 10'h000, 4'b0000, 2'b00);
    step(10'h3FF, 1'b0, 1'b0, "rst1", 10'h000, 4'b0000, 2'b00);
    rst = 1'b0;

    // Cabin call floor3 from floor1.
    step(10'h100, 1'b0, 1'b0, "c3_req", 10'h100, 4'b0000, 2'b00);
    step(10'h000, 1'b0, 1'b0, "c3_go",  10'h100, 4'b1000, 2'b01);
    step(10'h000, 1'b1, 1'b0, "c3_f2",  10'h100, 4'b1001, 2'b01);
    step(10'h000, 1'b1, 1'b0, "c3_f3",  10'h100, 4'b0010, 2'b00);
    step(10'h000, 1'b0, 1'b1, "c3_dup", 10'h100, 4'b0010, 2'b00);
    step(10'h000, 1'b0, 1'b0, "c3_srv", 10'h000, 4'b0010, 2'b00);
    step(10'h000, 1'b1, 1'b0, "rep_sensor", 10'h000, 4'b0010, 2'b00);

    // Up to floor4, door timeout, re-press on the clearing cycle.
    step(10'h200, 1'b0, 1'b0, "c4_req", 10'h200, 4'b0010, 2'b00);
    step(10'h000, 1'b0, 1'b0, "c4_go",  10'h200, 4'b1010, 2'b01);
    step(10'h000, 1'b1, 1'b0, "c4_arr", 10'h200, 4'b0011, 2'b00);
    step(10'h000, 1'b0, 1'b0, "to1",    10'h200, 4'b0011, 2'b00);
    step(10'h000, 1'b0, 1'b0, "to2",    10'h200, 4'b0011, 2'b00);
    step(10'h000, 1'b0, 1'b0, "to3",    10'h200, 4'b0011, 2'b00);
    step(10'h200, 1'b0, 1'b0, "to_clr_set", 10'h200, 4'b0011, 2'b00);
    step(10'h000, 1'b0, 1'b0, "re_stop", 10'h200, 4'b0011, 2'b00);
    step(10'h000, 1'b0, 1'b0, "re_to1", 10'h200, 4'b0011, 2'b00);
    step(10'h000, 1'b0, 1'b0, "re_to2", 10'h200, 4'b0011, 2'b00);
    step(10'h000, 1'b0, 1'b0, "re_to3", 10'h200, 4'b0011, 2'b00);
    step(10'h000, 1'b0, 1'b0, "re_clr", 10'h000, 4'b0011, 2'b00);

    // Down to floor3 so the cabin idles there heading down.
    step(10'h100, 1'b0, 1'b0, "c3b_req", 10'h100, 4'b0011, 2'b00);
    step(10'h000, 1'b0, 1'b0, "c3b_go",  10'h100, 4'b1111, 2'b10);
    step(10'h000, 1'b1, 1'b0, "c3b_arr", 10'h100, 4'b0110, 2'b00);
    step(10'h000, 1'b0, 1'b1, "c3b_dup", 10'h100, 4'b0110, 2'b00);
    step(10'h000, 1'b0, 1'b0, "c3b_srv", 10'h000, 4'b0110, 2'b00);

    // Floor1-up and floor4-cabin together: floor1 first, then floor4.
    step(10'h201, 1'b0, 1'b0, "dual_req",  10'h201, 4'b0110, 2'b00);
    step(10'h000, 1'b0, 1'b0, "dual_go",   10'h201, 4'b1110, 2'b10);
    step(10'h000, 1'b1, 1'b0, "dual_f2",   10'h201, 4'b1101, 2'b10);
    step(10'h000, 1'b1, 1'b0, "dual_f1",   10'h201, 4'b0000, 2'b00);
    step(10'h000, 1'b0, 1'b1, "dual_dup",  10'h201, 4'b0000, 2'b00);
    step(10'h000, 1'b0, 1'b0, "dual_srv1", 10'h200, 4'b0000, 2'b00);
    step(10'h000, 1'b0, 1'b0, "dual_up",   10'h200, 4'b1000, 2'b01);
    step(10'h000, 1'b1, 1'b0, "dual_u2",   10'h200, 4'b1001, 2'b01);
    step(10'h000, 1'b1, 1'b0, "dual_u3",   10'h200, 4'b1010, 2'b01);
    step(10'h000, 1'b1, 1'b0, "dual_f4",   10'h200, 4'b0011, 2'b00);
    step(10'h000, 1'b0, 1'b1, "dual_dup4", 10'h200, 4'b0011, 2'b00);
    step(10'h000, 1'b0, 1'b0, "dual_srv4", 10'h000, 4'b0011, 2'b00);

    // Back to floor1, served by timeout.
    step(10'h040, 1'b0, 1'b0, "c1_req", 10'h040, 4'b0011, 2'b00);
    step(10'h000, 1'b0, 1'b0, "c1_go",  10'h040, 4'b1111, 2'b10);
    step(10'h000, 1'b1, 1'b0, "c1_d3",  10'h040, 4'b1110, 2'b10);
    step(10'h000, 1'b1, 1'b0, "c1_d2",  10'h040, 4'b1101, 2'b10);
    step(10'h000, 1'b1, 1'b0, "c1_arr", 10'h040, 4'b0100, 2'b00);
    step(10'h000, 1'b0, 1'b0, "c1_to1", 10'h040, 4'b0100, 2'b00);
    step(10'h000, 1'b0, 1'b0, "c1_to2", 10'h040, 4'b0100, 2'b00);
    step(10'h000, 1'b0, 1'b0, "c1_to3", 10'h040, 4'b0100, 2'b00);
    step(10'h000, 1'b0, 1'b0, "c1_clr", 10'h000, 4'b0100, 2'b00);

    // Going up: pass floor2-down, stop floor4, return down to floor2.
    step(10'h204, 1'b0, 1'b0, "pass_req",  10'h204, 4'b0100, 2'b00);
    step(10'h000, 1'b0, 1'b0, "pass_go",   10'h204, 4'b1000, 2'b01);
    step(10'h000, 1'b1, 1'b0, "pass_f2",   10'h204, 4'b1001, 2'b01);
    step(10'h000, 1'b1, 1'b0, "pass_f3",   10'h204, 4'b1010, 2'b01);
    step(10'h000, 1'b1, 1'b0, "pass_f4",   10'h204, 4'b0011, 2'b00);
    step(10'h000, 1'b0, 1'b1, "pass_dup",  10'h204, 4'b0011, 2'b00);
    step(10'h000, 1'b0, 1'b0, "pass_srv4", 10'h004, 4'b0011, 2'b00);
    step(10'h000, 1'b0, 1'b0, "pass_flip", 10'h004, 4'b1111, 2'b10);
    step(10'h000, 1'b1, 1'b0, "pass_d3",   10'h004, 4'b1110, 2'b10);
    step(10'h000, 1'b1, 1'b0, "pass_f2dn", 10'h004, 4'b0101, 2'b00);
    step(10'h000, 1'b0, 1'b1, "pass_dup2", 10'h004, 4'b0101, 2'b00);
    step(10'h000, 1'b0, 1'b0, "pass_srv2", 10'h000, 4'b0101, 2'b00);

    // Reset while moving with requests pending.
    step(10'h200, 1'b0, 1'b0, "rstmv_req", 10'h200, 4'b0101, 2'b00);
    step(10'h000, 1'b0, 1'b0, "rstmv_go",  10'h200, 4'b1001, 2'b01);
    step(10'h040, 1'b0, 1'b0, "rstmv_add", 10'h240, 4'b1001, 2'b01);
    rst = 1'b1;
    step(10'h080, 1'b1, 1'b0, "rstmv",     10'h000, 4'b0000, 2'b00);
    rst = 1'b0;
    step(10'h000, 1'b0, 1'b0, "post_rst1", 10'h000, 4'b0000, 2'b00);
    step(10'h000, 1'b0, 1'b0, "post_rst2", 10'h000, 4'b0000, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/planificador_ascensor.md
PLANIFICADOR_ASCENSOR -- requirements
Module: planificador_ascensor

Interface
REQ-001 SHALL have parameter T_ESPERA, default 4: max cycles in DETENIDO waiting for trabajando to rise before the stop is abandoned.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port botones  input  10  one-cycle request pulses: [0] up floor1, [1] up floor2, [2] down floor2, [3] up floor3, [4] down floor3, [5] down floor4, [9:6] cabin call floors1..4.
REQ-005 SHALL have port sensor_piso  input  1  one-cycle pulse when the cabin reaches the next floor level.
REQ-006 SHALL have port trabajando  input  1  door controller busy (1 = doors not fully closed or opening).
REQ-007 SHALL have port pisos  output  10  registered pending-request vector, same bit map as botones.
REQ-008 SHALL have port estado  output  4  registered: [3] moving, [2] direction (0 up, 1 down), [1:0] floor index 0..3.
REQ-009 SHALL have port motor  output  2  registered: 01 up, 10 down, 00 stop; 11 never driven.

Function
REQ-010 SHALL set pisos[i] on botones[i]=1; a set and a clear of the same bit in one cycle SHALL leave the bit set.
REQ-011 SHALL implement FSM states REPOSO, MOVIENDO, DETENIDO; estado[3]=1 only in MOVIENDO; motor=00 outside MOVIENDO.
REQ-012 "Call at floor f" SHALL mean the cabin bit of f or any hall bit of f; "ahead" SHALL mean any pisos bit for a floor strictly beyond current floor in current direction.
REQ-013 REPOSO: if call at current floor -> DETENIDO next cycle; else if requests ahead -> MOVIENDO keeping direction; else if requests behind -> MOVIENDO with direction flipped; else stay.
REQ-014 MOVIENDO: motor SHALL be 01/10 per direction from the first MOVIENDO cycle; on sensor_piso the floor SHALL step by one toward the direction.
REQ-015 Floor index SHALL saturate at 0 and 3; sensor_piso pulse at a limit SHALL be ignored and the FSM SHALL go to DETENIDO.
REQ-016 After a step, SHALL go to DETENIDO if the new floor has a cabin call, a hall call in current direction, or any call with nothing ahead; otherwise remain MOVIENDO.
REQ-017 On entering DETENIDO with nothing ahead and only an opposite-direction hall call at the floor, direction SHALL flip in the same cycle.
REQ-018 DETENIDO: SHALL wait for trabajando 0->1 then 1->0; on the falling cycle SHALL clear cabin bit and hall bit(s) of current floor in current direction (floor1 up bit, floor4 down bit unconditionally), then -> REPOSO.
REQ-019 If trabajando stays 0 for T_ESPERA cycles after entering DETENIDO, SHALL clear the same bits and -> REPOSO.
REQ-020 sensor_piso outside MOVIENDO SHALL be ignored; botones SHALL be accepted in every state.
REQ-021 Latency: request pulse to pisos bit = 1 cycle; REPOSO decision to motor change = 1 cycle.

Reset
REQ-022 While rst=1 (sampled at clk): pisos=0, estado=4'b0000 (floor1, up, stopped), motor=00, state REPOSO, wait counter 0.
REQ-023 rst mid-MOVIENDO or mid-DETENIDO SHALL abandon all pending requests and motion on the next edge; botones during rst SHALL be dropped.

Verification
REQ-024 Reset, pulse botones[8] (cabin floor3) -> pisos=10'h100, motor=01; two sensor_piso pulses -> estado=4'b0010, motor=00; trabajando 1 then 0 -> pisos=0, REPOSO.
REQ-025 At floor3 idle, botones[0] and botones[9] same cycle -> direction down first to floor1 (estado[1:0]=00), serve, then up to floor4; pisos clears bit0 then bit9.
REQ-026 Moving up from floor1 with pisos bit2 (down floor2) and bit9 pending -> no stop at floor2, stop floor4, flip to down, stop floor2 clearing bit2.
REQ-027 DETENIDO with trabajando held 0 -> after 4 cycles served bits cleared, REPOSO; botones pulse on the clear cycle for the same bit -> bit stays 1.
REQ-028 rst asserted one cycle while MOVIENDO with pending requests -> next cycle pisos=0, estado=0, motor=00; sensor_piso pulse in REPOSO -> estado unchanged.
